// File: rtl/bp_fe_pkg.sv
// Front-end next-PC generator shared types.
// State codes, next-PC source codes and the RAS run code.
package bp_fe_pkg;

    typedef enum logic [1:0] {
        e_npc_reset = 2'b00,
        e_npc_run   = 2'b01,
        e_npc_stall = 2'b10,
        e_npc_redir = 2'b11
    } bp_fe_npc_state_e;

    typedef enum logic [1:0] {
        e_src_redirect = 2'b00,
        e_src_ras      = 2'b01,
        e_src_btb      = 2'b10,
        e_src_seq      = 2'b11
    } bp_fe_npc_src_e;

    localparam logic [1:0] ras_run_code_lp  = 2'b01;
    localparam logic [1:0] ras_idle_code_lp = 2'b00;

endpackage

// File: rtl/bp_fe_npc_mux.sv
// Next-PC priority select: redirect > RAS > BTB > PC+4.
// The PC+4 adder wraps silently at the top of the address space.
module bp_fe_npc_mux
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39
) (
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    input  logic                     ras_v_i,
    input  logic [vaddr_width_p-1:0] ras_tgt_i,
    input  logic                     btb_v_i,
    input  logic [vaddr_width_p-1:0] btb_tgt_i,
    input  logic [vaddr_width_p-1:0] pc_i,
    output logic [vaddr_width_p-1:0] npc_o,
    output bp_fe_npc_src_e           src_o
);

    logic [vaddr_width_p-1:0] pc_plus4;

    assign pc_plus4 = pc_i + vaddr_width_p'(4);

    // Highest-priority valid source wins
    always_comb begin
        npc_o = pc_plus4;
        src_o = e_src_seq;
        if (redirect_v_i) begin
            npc_o = redirect_pc_i;
            src_o = e_src_redirect;
        end else if (ras_v_i) begin
            npc_o = ras_tgt_i;
            src_o = e_src_ras;
        end else if (btb_v_i) begin
            npc_o = btb_tgt_i;
            src_o = e_src_btb;
        end
    end

endmodule

// File: rtl/bp_fe_npc_gen.sv
// Front-end next-PC generator with two-stage fetch (IF1 issue, IF2 return).
// Presents the IF2 PC/instruction to the RAS and consumes its return target.
module bp_fe_npc_gen
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p = 39,
    parameter int instr_width_p = 32,
    parameter logic [vaddr_width_p-1:0] boot_pc_p = vaddr_width_p'(32'h8000_0000)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     redirect_v_i,
    input  logic [vaddr_width_p-1:0] redirect_pc_i,
    output logic                     fetch_v_o,
    output logic [vaddr_width_p-1:0] fetch_pc_o,
    input  logic                     fetch_ready_i,
    input  logic                     icache_v_i,
    input  logic [instr_width_p-1:0] icache_data_i,
    input  logic                     btb_tgt_v_i,
    input  logic [vaddr_width_p-1:0] btb_tgt_i,
    output logic [1:0]               ras_state_o,
    output logic [vaddr_width_p-1:0] ras_pc_o,
    output logic [instr_width_p-1:0] ras_instr_o,
    input  logic                     ras_tgt_v_i,
    input  logic [vaddr_width_p-1:0] ras_tgt_i,
    output logic [1:0]               fsm_state_o
);

    bp_fe_npc_state_e         state_q;
    logic [vaddr_width_p-1:0] pc_if1_q;
    logic [vaddr_width_p-1:0] pc_if2_q;
    logic                     if2_v_q;

    logic                     active;
    logic                     redirect_take;
    logic                     ras_take;
    logic [vaddr_width_p-1:0] npc;
    bp_fe_npc_src_e           npc_src;

    assign active        = (state_q == e_npc_run) | (state_q == e_npc_stall);
    assign redirect_take = redirect_v_i & (state_q != e_npc_reset);

    // IF2 instruction is reported valid only when a redirect is not squashing it
    always_comb begin
        ras_state_o = ras_idle_code_lp;
        if (active & if2_v_q & icache_v_i & ~redirect_v_i)
            ras_state_o = ras_run_code_lp;
    end

    assign ras_take    = ras_tgt_v_i & (ras_state_o == ras_run_code_lp);
    assign fetch_v_o   = active;
    assign fetch_pc_o  = pc_if1_q;
    assign ras_pc_o    = pc_if2_q;
    assign ras_instr_o = icache_data_i;
    assign fsm_state_o = state_q;

    bp_fe_npc_mux #(
        .vaddr_width_p(vaddr_width_p)
    ) mux (
        .redirect_v_i (redirect_take),
        .redirect_pc_i(redirect_pc_i),
        .ras_v_i      (ras_take),
        .ras_tgt_i    (ras_tgt_i),
        .btb_v_i      (btb_tgt_v_i & fetch_ready_i),
        .btb_tgt_i    (btb_tgt_i),
        .pc_i         (pc_if1_q),
        .npc_o        (npc),
        .src_o        (npc_src)
    );

    // Fetch FSM and IF1/IF2 pipeline registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= e_npc_reset;
            pc_if1_q <= boot_pc_p;
            pc_if2_q <= '0;
            if2_v_q  <= 1'b0;
        end else if (state_q == e_npc_reset) begin
            state_q <= e_npc_run;
            if2_v_q <= 1'b0;
        end else if (npc_src == e_src_redirect) begin
            state_q  <= e_npc_redir;
            pc_if1_q <= npc;
            if2_v_q  <= 1'b0;
        end else if (npc_src == e_src_ras) begin
            state_q  <= e_npc_run;
            pc_if1_q <= npc;
            if2_v_q  <= 1'b0;
        end else if (state_q == e_npc_redir) begin
            state_q <= e_npc_run;
            if2_v_q <= 1'b0;
        end else if (fetch_ready_i) begin
            state_q  <= e_npc_run;
            pc_if2_q <= pc_if1_q;
            pc_if1_q <= npc;
            if2_v_q  <= 1'b1;
        end else begin
            state_q <= e_npc_stall;
            if2_v_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_fe_npc_gen.sv
// Self-checking bench for bp_fe_npc_gen.
// Cycle vectors with hand-computed expectations plus a RAS-priority sequence.
module tb_bp_fe_npc_gen;

    typedef logic [38:0] va_t;

    typedef struct {
        logic rst_n;
        logic rv;
        va_t  rpc;
        logic rdy;
        logic icv;
        logic btbv;
        va_t  btb;
        logic rasv;
        va_t  ras;
        logic efv;
        va_t  epc;
        logic [1:0] ers;
        va_t  erpc;
        logic [1:0] efsm;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_v;
    va_t         redirect_pc;
    logic        fetch_v;
    va_t         fetch_pc;
    logic        fetch_ready;
    logic        icache_v;
    logic [31:0] icache_data;
    logic        btb_tgt_v;
    va_t         btb_tgt;
    logic [1:0]  ras_state;
    va_t         ras_pc;
    logic [31:0] ras_instr;
    logic        ras_tgt_v;
    va_t         ras_tgt;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    bp_fe_npc_gen dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .redirect_v_i (redirect_v),
        .redirect_pc_i(redirect_pc),
        .fetch_v_o    (fetch_v),
        .fetch_pc_o   (fetch_pc),
        .fetch_ready_i(fetch_ready),
        .icache_v_i   (icache_v),
        .icache_data_i(icache_data),
        .btb_tgt_v_i  (btb_tgt_v),
        .btb_tgt_i    (btb_tgt),
        .ras_state_o  (ras_state),
        .ras_pc_o     (ras_pc),
        .ras_instr_o  (ras_instr),
        .ras_tgt_v_i  (ras_tgt_v),
        .ras_tgt_i    (ras_tgt),
        .fsm_state_o  (fsm_state)
    );

    function automatic vec_t mk(
        input logic rst_n, input logic rv, input va_t rpc,
        input logic rdy, input logic icv,
        input logic btbv, input va_t btb,
        input logic rasv, input va_t ras,
        input logic efv, input va_t epc, input logic [1:0] ers,
        input va_t erpc, input logic [1:0] efsm);
        vec_t v;
        v.rst_n = rst_n; v.rv = rv; v.rpc = rpc;
        v.rdy = rdy; v.icv = icv;
        v.btbv = btbv; v.btb = btb;
        v.rasv = rasv; v.ras = ras;
        v.efv = efv; v.epc = epc; v.ers = ers;
        v.erpc = erpc; v.efsm = efsm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic [31:0] data);
        reset_n     = v.rst_n;
        redirect_v  = v.rv;
        redirect_pc = v.rpc;
        fetch_ready = v.rdy;
        icache_v    = v.icv;
        icache_data = data;
        btb_tgt_v   = v.btbv;
        btb_tgt     = v.btb;
        ras_tgt_v   = v.rasv;
        ras_tgt     = v.ras;
    endtask

    initial begin
        // rst rv rpc rdy icv btbv btb rasv ras | fv pc rs rpc fsm
        vq.push_back(mk(1,0,0,1,0,0,0,0,0, 0,'h80000000,0,0,0));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h80000000,0,0,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h80000004,1,'h80000000,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h80000008,1,'h80000004,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h8000000C,1,'h80000008,1));
        vq.push_back(mk(1,0,0,0,1,0,0,0,0, 1,'h80000010,1,'h8000000C,1));
        vq.push_back(mk(1,0,0,0,1,0,0,0,0, 1,'h80000010,0,'h8000000C,2));
        vq.push_back(mk(1,0,0,0,0,0,0,0,0, 1,'h80000010,0,'h8000000C,2));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h80000010,0,'h8000000C,2));
        vq.push_back(mk(1,0,0,1,1,1,'h5000,0,0, 1,'h80000014,1,'h80000010,1));
        vq.push_back(mk(1,1,'h1000,1,1,0,0,0,0, 1,'h5000,0,'h80000014,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 0,'h1000,0,'h80000014,3));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h1000,0,'h80000014,1));
        vq.push_back(mk(1,0,0,0,1,0,0,1,'h2000, 1,'h1004,1,'h1000,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h2000,0,'h1000,1));
        vq.push_back(mk(1,1,'h3000,1,1,1,'h4000,1,'h2000, 1,'h2004,0,'h2000,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 0,'h3000,0,'h2000,3));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h3000,0,'h2000,1));
        vq.push_back(mk(1,0,0,1,0,0,0,0,0, 1,'h3004,0,'h3000,1));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h3008,1,'h3004,1));
        vq.push_back(mk(1,1,39'h7F_FFFF_FFFC,1,1,0,0,0,0, 1,'h300C,0,'h3008,1));
        vq.push_back(mk(1,0,0,1,0,0,0,0,0, 0,39'h7F_FFFF_FFFC,0,'h3008,3));
        vq.push_back(mk(1,0,0,1,0,0,0,0,0, 1,39'h7F_FFFF_FFFC,0,'h3008,1));
        vq.push_back(mk(1,0,0,0,1,0,0,0,0, 1,0,1,39'h7F_FFFF_FFFC,1));
        vq.push_back(mk(1,0,0,0,0,0,0,0,0, 1,0,0,39'h7F_FFFF_FFFC,2));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 1,0,0,39'h7F_FFFF_FFFC,2));
        vq.push_back(mk(1,0,0,1,0,0,0,0,0, 0,'h80000000,0,0,0));
        vq.push_back(mk(1,0,0,1,1,0,0,0,0, 1,'h80000000,0,0,1));

        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0), 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            logic [31:0] d;
            d = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            drive(vq[i], d);
            #1;
            chk($sformatf("v%0d fetch_v", i), 64'(fetch_v), 64'(vq[i].efv));
            chk($sformatf("v%0d fetch_pc", i), 64'(fetch_pc), 64'(vq[i].epc));
            chk($sformatf("v%0d ras_state", i), 64'(ras_state), 64'(vq[i].ers));
            chk($sformatf("v%0d ras_pc", i), 64'(ras_pc), 64'(vq[i].erpc));
            chk($sformatf("v%0d fsm", i), 64'(fsm_state), 64'(vq[i].efsm));
            chk($sformatf("v%0d ras_instr", i), 64'(ras_instr), 64'(d));
        end

        // RAS target beats a same-cycle BTB hit with fetch_ready_i=1
        @(negedge clk);
        drive(mk(1,0,0,1,1,1,'h7000,1,'h6000, 0,0,0,0,0), 32'h1234_5678);
        #1;
        chk("ras_prio ras_state", 64'(ras_state), 64'(2'b01));
        chk("ras_prio ras_pc", 64'(ras_pc), 64'h8000_0000);
        chk("ras_prio fetch_pc", 64'(fetch_pc), 64'h8000_0004);
        @(negedge clk);
        drive(mk(1,0,0,1,1,0,0,0,0, 0,0,0,0,0), 32'h0);
        #1;
        chk("ras_next fetch_pc", 64'(fetch_pc), 64'h6000);
        chk("ras_next ras_state", 64'(ras_state), 64'(2'b00));
        chk("ras_next fsm", 64'(fsm_state), 64'(2'b01));
        @(negedge clk);
        #1;
        chk("ras_seq fetch_pc", 64'(fetch_pc), 64'h6004);
        chk("ras_seq ras_pc", 64'(ras_pc), 64'h6000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
